// File: rtl/demux_rr_scheduler_pkg.sv
// demux_sched_pkg: shared sizes, FSM state type and one-hot helper for the round-robin demux scheduler.
package demux_sched_pkg;
    localparam int NCH = 16;
    localparam int SELW = 4;
    localparam int DW = 8;
    typedef enum logic {IDLE, SEND} state_t;
    function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] i);
        return NCH'(1) << i;
    endfunction
endpackage

// File: rtl/demux_rr_scheduler_if.sv
// demux_rr_scheduler_if: producer/consumer handshake and demux select bundle for the scheduler.
interface demux_rr_scheduler_if;
    import demux_sched_pkg::*;
    logic [NCH-1:0]  en_mask;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_ready;
    logic [NCH-1:0]  ch_ready;
    logic [SELW-1:0] sel;
    logic [NCH-1:0]  out_valid;
    logic [DW-1:0]   out_data;
    logic            busy;
    logic            drop_pulse;
    modport slave (
        input  en_mask, in_valid, in_data, ch_ready,
        output in_ready, sel, out_valid, out_data, busy, drop_pulse
    );
    modport master (
        output en_mask, in_valid, in_data, ch_ready,
        input  in_ready, sel, out_valid, out_data, busy, drop_pulse
    );
endinterface

// File: rtl/demux_rr_scheduler_rr_pick.sv
// rr_pick: first enabled channel at or after ptr in cyclic order.
module rr_pick
    import demux_sched_pkg::*;
(
    input  logic [NCH-1:0]  i_mask,
    input  logic [SELW-1:0] i_ptr,
    output logic [SELW-1:0] o_idx,
    output logic            o_any
);
    logic [NCH-1:0]  w_rot;
    logic [SELW-1:0] w_off;
    // Rotating the doubled mask puts channel ptr at bit 0, so a plain lowest-bit search is cyclic.
    assign w_rot = NCH'({i_mask, i_mask} >> i_ptr);
    always_comb begin
        w_off = '0;
        for (int j = NCH - 1; j >= 0; j--)
            if (w_rot[j]) w_off = SELW'(j);
    end
    assign o_idx = i_ptr + w_off;
    assign o_any = |i_mask;
endmodule

// File: rtl/demux_rr_scheduler.sv
// demux_rr_scheduler: round-robin distribution of one word stream over 16 enabled channels.
// Optional watchdog drop of a stuck word when DEMUX_SCHED_TIMEOUT_EN is defined.
module demux_rr_scheduler
    import demux_sched_pkg::*;
`ifdef DEMUX_SCHED_TIMEOUT_EN
#(
    parameter int TIMEOUT = 255
)
`endif
(
    input  logic               clk,
    input  logic               rst_n,
    demux_rr_scheduler_if.slave bus
);
    state_t          r_state, w_state_nxt;
    logic [SELW-1:0] r_sel, r_ptr, w_pp, w_idx;
    logic [DW-1:0]   r_data;
    logic            w_any, w_hs, w_ready, w_cap, w_drop;
    assign w_hs = (r_state == SEND) && bus.ch_ready[r_sel];
    // A completing handshake frees the slot, so the next pick already starts after it.
    assign w_pp = w_hs ? r_sel + SELW'(1) : r_ptr;
    rr_pick u_pick (
        .i_mask (bus.en_mask),
        .i_ptr  (w_pp),
        .o_idx  (w_idx),
        .o_any  (w_any)
    );
    assign w_ready = w_any && ((r_state == IDLE) || w_hs);
    assign w_cap   = bus.in_valid && w_ready;
    always_comb begin
        w_state_nxt = r_state;
        w_state_nxt = w_cap ? SEND : (w_hs || w_drop) ? IDLE : r_state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel  <= '0;
            r_ptr  <= '0;
            r_data <= '0;
        end else begin
            if (w_hs || w_drop) r_ptr <= r_sel + SELW'(1);
            if (w_cap) begin
                r_sel  <= w_idx;
                r_data <= bus.in_data;
            end
        end
    end
`ifdef DEMUX_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    logic          r_drop;
    assign w_drop = (r_state == SEND) && !w_hs && (r_cnt == CW'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_drop <= 1'b0;
        end else begin
            r_cnt  <= w_cap ? '0 : (r_state == SEND) ? r_cnt + CW'(1) : r_cnt;
            r_drop <= w_drop;
        end
    end
    assign bus.drop_pulse = r_drop;
`else
    assign w_drop         = 1'b0;
    assign bus.drop_pulse = 1'b0;
`endif
    assign bus.in_ready  = w_ready;
    assign bus.sel       = r_sel;
    assign bus.out_data  = r_data;
    assign bus.busy      = (r_state == SEND);
    assign bus.out_valid = (r_state == SEND) ? onehot(r_sel) : '0;
endmodule

// File: tb/tb_demux_rr_scheduler.sv
// tb_demux_rr_scheduler: vector table, directed corner sequences and random traffic against a queue-free cyclic model.
module tb_demux_rr_scheduler;
    import demux_sched_pkg::*;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;
    demux_rr_scheduler_if bus();
    demux_rr_scheduler dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    int total = 0;
    int bad = 0;
    bit m_held;
    int m_tgt, m_ptr;
    logic [7:0] m_data;
    typedef struct {
        logic [15:0] mask;
        logic        v;
        logic [7:0]  d;
        logic [15:0] rdy;
        logic [15:0] eov;
        int          esel;
        logic [7:0]  edata;
        logic        eir;
    } vec_t;
    vec_t tbl[8];
    function automatic int pick(input logic [15:0] mask, input int p);
        for (int k = 0; k < NCH; k++)
            if (mask[(p + k) % NCH]) return (p + k) % NCH;
        return -1;
    endfunction
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask
    task automatic model_reset();
        m_held = 0;
        m_tgt = 0;
        m_ptr = 0;
        m_data = '0;
    endtask
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask
    task automatic step(input logic [15:0] mask, input logic v, input logic [7:0] d, input logic [15:0] rdy);
        bit hs, ir;
        @(negedge clk);
        bus.en_mask = mask;
        bus.in_valid = v;
        bus.in_data = d;
        bus.ch_ready = rdy;
        #1;
        hs = m_held && rdy[m_tgt];
        ir = (!m_held || hs) && (mask != 0);
        chk("in_ready", bus.in_ready, ir);
        chk("out_valid", bus.out_valid, m_held ? (32'd1 << m_tgt) : 32'd0);
        chk("busy", bus.busy, m_held);
        chk("drop_pulse", bus.drop_pulse, 0);
        if (m_held) begin
            chk("sel", bus.sel, m_tgt);
            chk("out_data", bus.out_data, m_data);
        end
        if (hs) begin
            m_ptr = (m_tgt + 1) % NCH;
            m_held = 0;
        end
        if (v && ir) begin
            m_tgt = pick(mask, m_ptr);
            m_data = d;
            m_held = 1;
        end
    endtask
    initial begin
        logic [15:0] mk, rd;
        bus.en_mask = '0;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.ch_ready = '0;
        tbl[0] = '{16'h8421, 1, 8'hA0, 16'hFFFF, 16'h0000, 0,  8'h00, 1};
        tbl[1] = '{16'h8421, 1, 8'hA1, 16'hFFFF, 16'h0001, 0,  8'hA0, 1};
        tbl[2] = '{16'h8421, 1, 8'hA2, 16'hFFFF, 16'h0020, 5,  8'hA1, 1};
        tbl[3] = '{16'h8421, 1, 8'hA3, 16'hFFFF, 16'h0400, 10, 8'hA2, 1};
        tbl[4] = '{16'h8421, 1, 8'hA4, 16'hFFFF, 16'h8000, 15, 8'hA3, 1};
        tbl[5] = '{16'h8421, 1, 8'hA5, 16'hFFFF, 16'h0001, 0,  8'hA4, 1};
        tbl[6] = '{16'h8421, 0, 8'h00, 16'hFFFF, 16'h0020, 5,  8'hA5, 1};
        tbl[7] = '{16'h8421, 0, 8'h00, 16'hFFFF, 16'h0000, 5,  8'hA5, 1};
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sel", bus.sel, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_drop", bus.drop_pulse, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(tbl[i].mask, tbl[i].v, tbl[i].d, tbl[i].rdy);
            chk("tbl_out_valid", bus.out_valid, tbl[i].eov);
            chk("tbl_sel", bus.sel, tbl[i].esel);
            chk("tbl_out_data", bus.out_data, tbl[i].edata);
            chk("tbl_in_ready", bus.in_ready, tbl[i].eir);
        end
        do_reset();
        for (int i = 0; i < 18; i++) begin
            step(16'hFFFF, i < 17, 8'(i), 16'hFFFF);
            if (i >= 1) begin
                chk("walk_sel", bus.sel, (i - 1) % 16);
                chk("walk_data", bus.out_data, i - 1);
            end
        end
        do_reset();
        step(16'h0008, 1, 8'h33, 16'hFFFF);
        for (int c = 0; c < 10; c++) begin
            step(c < 3 ? 16'h0008 : 16'h0001, 1, 8'h40 + 8'(c), 16'hFFF7);
            chk("stall_sel", bus.sel, 3);
            chk("stall_data", bus.out_data, 8'h33);
            chk("stall_in_ready", bus.in_ready, 0);
        end
        step(16'h0001, 1, 8'h55, 16'hFFFF);
        step(16'h0001, 0, 8'h00, 16'hFFFF);
        chk("after_stall_sel", bus.sel, 0);
        chk("after_stall_data", bus.out_data, 8'h55);
        for (int c = 0; c < 20; c++) begin
            step(16'h0000, 1, 8'h66, 16'hFFFF);
            chk("nomask_in_ready", bus.in_ready, 0);
            chk("nomask_out_valid", bus.out_valid, 0);
        end
        step(16'h0100, 1, 8'h77, 16'h0000);
        step(16'h0100, 0, 8'h00, 16'h0100);
        chk("mask8_sel", bus.sel, 8);
        chk("mask8_out_valid", bus.out_valid, 16'h0100);
        step(16'hFFFF, 1, 8'h99, 16'h0000);
        step(16'hFFFF, 0, 8'h00, 16'h0000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_busy", bus.busy, 0);
        chk("async_sel", bus.sel, 0);
        chk("async_data", bus.out_data, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step(16'hFFFF, 1, 8'hAB, 16'hFFFF);
        step(16'hFFFF, 0, 8'h00, 16'hFFFF);
        chk("post_rst_sel", bus.sel, 0);
        chk("post_rst_data", bus.out_data, 8'hAB);
        for (int n = 0; n < 400; n++) begin
            case ($urandom_range(0, 9))
                0:       mk = 16'h0000;
                1:       mk = 16'h0001 << $urandom_range(0, 15);
                default: mk = 16'($urandom);
            endcase
            rd = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom & $urandom);
            step(mk, $urandom_range(0, 3) != 0, 8'($urandom), rd);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/demux_rr_scheduler.md
Name: demux_rr_scheduler

Overview:
- Round-robin scheduler that distributes a single input word stream across 16 output channels.
- Emits a 4-bit channel select plus a one-hot valid for the 1-to-16 demultiplexer datapath.
- Performs per-channel valid/ready handshakes.
- Sits between a single upstream producer and 16 downstream consumers; skips channels disabled by a software mask.

Parameters:
- NCH, 16, number of output channels (fixed at 16 for this revision).
- SELW, 4, select width, equals log2(NCH).
- DW, 8, data word width.
- TIMEOUT, 255, watchdog limit in cycles; used only when DEMUX_SCHED_TIMEOUT_EN is defined.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- en_mask  input  16  channel enable; bit i=1 makes channel i eligible.
- in_valid  input  1  upstream word valid.
- in_data  input  DW  upstream word.
- in_ready  output  1  scheduler can accept a word this cycle.
- ch_ready  input  16  per-channel consumer ready.
- sel  output  SELW  registered target channel index; drives the demux select.
- out_valid  output  16  one-hot valid; bit sel set while a word is held, else all zero.
- out_data  output  DW  registered held word.
- busy  output  1  high in SEND state.
- drop_pulse  output  1  one-cycle pulse when a word is discarded by timeout; tied 0 without the macro.

Behaviour:
- Reset (async assert, sync-release domain of clk):
  - state=IDLE, sel=0, out_valid=0, out_data=0, busy=0, drop_pulse=0.
  - Round-robin pointer ptr=0; watchdog count=0.
- States: IDLE (nothing held), SEND (word held, waiting for target consumer).
- Target pick (combinational): first i in cyclic order ptr, ptr+1, ..., ptr+15 (mod 16) with en_mask[i]=1. ch_ready is NOT considered; the target is fixed at capture.
- IDLE:
  - in_ready = |en_mask.
  - On in_valid && in_ready: capture in_data into out_data, sel = picked index, go to SEND.
  - out_valid is visible the next cycle (latency 1).
- SEND:
  - out_valid = one-hot(sel), busy=1.
  - Handshake completes when ch_ready[sel]=1; then ptr = sel+1 (15 wraps to 0).
  - On handshake: in_ready = |en_mask (combinational path ch_ready -> in_ready, documented).
    - If in_valid is also high, capture the next word in the same cycle and stay in SEND with the new target.
    - The pick for that word uses the updated pointer, sel+1.
  - On handshake with no input: return to IDLE, out_valid=0.
  - No handshake: in_ready=0; sel, out_data and out_valid are held stable.
- Sustained throughput is one word per cycle when consumers are ready.
- Boundary conditions:
  - en_mask all zero: in_ready=0, block stays IDLE indefinitely.
  - en_mask changes during SEND: the held target is unaffected; the new mask applies from the next pick.
  - Only one channel enabled: every word goes to that channel.
  - ch_ready asserted on a non-target channel: ignored.
  - rst_n asserted mid-SEND: held word is discarded, outputs return to reset values immediately.

Optional Feature:
- Macro: DEMUX_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit (clog2(TIMEOUT+1)) counter clears on entry to SEND and increments each SEND cycle without handshake.
  - On reaching TIMEOUT without handshake: the word is dropped, drop_pulse=1 for one cycle, ptr = sel+1, state = IDLE (no same-cycle capture).
  - A handshake in the same cycle as TIMEOUT wins; no drop occurs.
- Undefined: no counter; drop_pulse is constant 0; SEND waits indefinitely.

Decomposition:
- Package demux_sched_pkg:
  - NCH and SELW localparams.
  - State enum typedef (IDLE, SEND).
  - One-hot-from-index function.
- Sub-module rr_pick: combinational cyclic priority finder.
  - Inputs: mask[15:0], ptr[3:0].
  - Outputs: idx[3:0], any.
  - Implemented with a doubled-mask rotate-and-priority scheme.

Test Plan:
- Reset then en_mask=16'hFFFF, in_valid held, ch_ready=16'hFFFF, data 0x00..0x0F -> out_valid walks bit0..bit15, one word per cycle, then wraps to bit0; out_data matches sel.
- en_mask=16'h8421, 6 words -> targets 0, 5, 10, 15, 0, 5.
- Word captured for ch3, ch_ready=0 for 10 cycles, mask changed to 16'h0001 meanwhile -> sel=3 and out_data held stable, in_ready=0; after ch_ready[3]=1 the next word goes to ch0.
- en_mask=0 with in_valid=1 -> in_ready=0 and out_valid=0 for 20 cycles; set mask 16'h0100 -> next word to ch8.
- rst_n pulsed low while in SEND -> out_valid=0, busy=0 asynchronously; first post-reset word targets ch0.
- With DEMUX_SCHED_TIMEOUT_EN, TIMEOUT=4, target ch2 never ready -> drop_pulse high exactly 4 cycles after entering SEND, then IDLE; next word targets ch3.
